// File: rtl/dds_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dds_ctrl_pkg
//  Brief    : Shared types, mode constants and step/clamp arithmetic for the
//             DDS frequency sweep controller.
//  Revision : 1.0 - initial release
// ============================================================================
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_TRI    = 1'b1;

    // Wide enough for any FREQ_W up to 32 plus sign and carry headroom.
    localparam int CALC_W = 34;

    function automatic logic signed [CALC_W-1:0] add_clamp(
        input logic signed [CALC_W-1:0] base,
        input logic signed [CALC_W-1:0] step,
        input logic signed [CALC_W-1:0] lo,
        input logic signed [CALC_W-1:0] hi
    );
        logic signed [CALC_W-1:0] sum;
        logic signed [CALC_W-1:0] res;
        sum = base + step;
        res = sum;
        if (sum < lo) begin
            res = lo;
        end else if (sum > hi) begin
            res = hi;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_dwell_timer
//  Brief    : Enable-gated dwell counter with clear; pulses o_tc on the last
//             cycle of the dwell period (a dwell of 0 behaves as 1).
//  Revision : 1.0 - initial release
// ============================================================================
module sweep_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_tc
);

    logic [DWELL_W-1:0] r_count;
    logic [DWELL_W-1:0] w_last;

    assign w_last = (i_dwell == '0) ? '0 : (i_dwell - 1'b1);
    assign o_tc   = i_en && (r_count == w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : (r_count + 1'b1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_ctrl
//  Brief    : Walks the NCO frequency word between latched bounds, one signed
//             step per dwell period, handing each word over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int SIZE_VALUE = 7,
    parameter int FREQ_W     = 16,
    parameter int DWELL_W    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_mode,
    input  logic signed [SIZE_VALUE:0]   i_step,
    input  logic        [FREQ_W-1:0]     i_f_min,
    input  logic        [FREQ_W-1:0]     i_f_max,
    input  logic        [DWELL_W-1:0]    i_dwell,
    output logic        [FREQ_W-1:0]     o_fword,
    output logic                         o_fword_vld,
    input  logic                         i_fword_rdy,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int EXT_W  = CALC_W - FREQ_W;
    localparam int STEP_X = CALC_W - SIZE_VALUE - 1;

    sweep_state_t              r_state;
    logic        [FREQ_W-1:0]  r_fword;
    logic        [FREQ_W-1:0]  r_f_min;
    logic        [FREQ_W-1:0]  r_f_max;
    logic signed [SIZE_VALUE:0] r_step;
    logic        [DWELL_W-1:0] r_dwell;
    logic                      r_mode;
    logic                      r_dir_down;
    logic                      r_vld;
    logic                      r_done;
    logic                      r_err;

    logic signed [CALC_W-1:0]  w_base;
    logic signed [CALC_W-1:0]  w_lo;
    logic signed [CALC_W-1:0]  w_hi;
    logic signed [CALC_W-1:0]  w_step_ext;
    logic signed [CALC_W-1:0]  w_eff_step;
    logic signed [CALC_W-1:0]  w_sum;
    logic        [FREQ_W-1:0]  w_next;
    logic        [FREQ_W-1:0]  w_term;
    logic                      w_reversed;
    logic                      w_flip;
    logic                      w_finish;
    logic                      w_accept;
    logic                      w_tmr_en;
    logic                      w_tc;

    // Bounds are unsigned words, so zero-extend them; the step keeps its sign.
    assign w_base     = {{EXT_W{1'b0}}, r_fword};
    assign w_lo       = {{EXT_W{1'b0}}, r_f_min};
    assign w_hi       = {{EXT_W{1'b0}}, r_f_max};
    assign w_step_ext = {{STEP_X{r_step[SIZE_VALUE]}}, r_step};

    // Travel direction that differs from the step's own sign walks it backwards.
    assign w_reversed = r_dir_down ^ r_step[SIZE_VALUE];
    assign w_eff_step = w_reversed ? -w_step_ext : w_step_ext;
    assign w_sum      = add_clamp(w_base, w_eff_step, w_lo, w_hi);
    assign w_next     = w_sum[FREQ_W-1:0];
    assign w_flip     = (r_mode == MODE_TRI) && (w_sum == (r_dir_down ? w_lo : w_hi));

    assign w_term     = r_dir_down ? r_f_min : r_f_max;
    assign w_finish   = (r_step == '0) || ((r_mode == MODE_SINGLE) && (r_fword == w_term));
    assign w_accept   = (r_state == ACK) && i_fword_rdy;
    assign w_tmr_en   = i_en && (r_state == DWELL);

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_accept),
        .i_en    (w_tmr_en),
        .i_dwell (r_dwell),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_fword    <= '0;
            r_f_min    <= '0;
            r_f_max    <= '0;
            r_step     <= '0;
            r_dwell    <= '0;
            r_mode     <= MODE_SINGLE;
            r_dir_down <= 1'b0;
            r_vld      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (i_stop) begin
                // Abort leaves the last word in place; the NCO keeps its own copy.
                r_state <= IDLE;
                r_vld   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start && i_en) begin
                            if (i_f_min > i_f_max) begin
                                r_err <= 1'b1;
                            end else begin
                                r_f_min    <= i_f_min;
                                r_f_max    <= i_f_max;
                                r_step     <= i_step;
                                r_dwell    <= i_dwell;
                                r_mode     <= i_mode;
                                r_dir_down <= i_step[SIZE_VALUE];
                                r_fword    <= i_step[SIZE_VALUE] ? i_f_max : i_f_min;
                                r_vld      <= 1'b1;
                                r_state    <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (i_fword_rdy) begin
                            r_vld <= 1'b0;
                            if (w_finish) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_state <= DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        if (w_tc) begin
                            r_fword <= w_next;
                            r_vld   <= 1'b1;
                            r_state <= ACK;
                            if (w_flip) begin
                                r_dir_down <= ~r_dir_down;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_vld   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_fword     = r_fword;
    assign o_fword_vld = r_vld;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_sweep_ctrl
//  Brief    : Self-checking bench for dds_sweep_ctrl against a behavioural
//             sweep model, with directed corners and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    localparam int SIZE_VALUE = 7;
    localparam int FREQ_W     = 16;
    localparam int DWELL_W    = 16;

    logic                      clk   = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en    = 1'b0;
    logic                      start = 1'b0;
    logic                      stop  = 1'b0;
    logic                      mode  = 1'b0;
    logic                      rdy   = 1'b0;
    logic signed [SIZE_VALUE:0] step = '0;
    logic [FREQ_W-1:0]         fmin  = '0;
    logic [FREQ_W-1:0]         fmax  = '0;
    logic [DWELL_W-1:0]        dwell = '0;
    logic [FREQ_W-1:0]         fword;
    logic                      vld, busy, done, err;

    dds_sweep_ctrl #(
        .SIZE_VALUE (SIZE_VALUE),
        .FREQ_W     (FREQ_W),
        .DWELL_W    (DWELL_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode      (mode),
        .i_step      (step),
        .i_f_min     (fmin),
        .i_f_max     (fmax),
        .i_dwell     (dwell),
        .o_fword     (fword),
        .o_fword_vld (vld),
        .i_fword_rdy (rdy),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 offering a word, 2 dwelling, 3 done.
    int m_phase = 0, m_word = 0, m_lo = 0, m_hi = 0, m_step = 0;
    int m_dwell = 1, m_remain = 0, m_mag = 0, m_nxt = 0;
    bit m_tri = 0, m_up = 1, m_vld = 0, m_done = 0, m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_word = 0; m_vld = 0; m_done = 0; m_err = 0; m_up = 1;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (stop) begin
                m_phase = 0;
                m_vld   = 0;
            end else begin
                case (m_phase)
                    0: if (start && en) begin
                        if (fmin > fmax) begin
                            m_err = 1;
                        end else begin
                            m_lo = int'(fmin); m_hi = int'(fmax); m_step = int'(step);
                            m_dwell = (dwell == 0) ? 1 : int'(dwell);
                            m_tri = mode; m_up = (m_step >= 0);
                            m_word = m_up ? m_lo : m_hi;
                            m_vld = 1; m_phase = 1;
                        end
                    end
                    1: if (rdy) begin
                        m_vld = 0;
                        if (m_step == 0 || (!m_tri && m_word == (m_up ? m_hi : m_lo))) begin
                            m_phase = 3; m_done = 1;
                        end else begin
                            m_phase = 2; m_remain = m_dwell;
                        end
                    end
                    2: if (en) begin
                        m_remain--;
                        if (m_remain == 0) begin
                            m_mag = (m_step < 0) ? -m_step : m_step;
                            m_nxt = m_word + (m_up ? m_mag : -m_mag);
                            if (m_nxt < m_lo) m_nxt = m_lo;
                            if (m_nxt > m_hi) m_nxt = m_hi;
                            if (m_tri && m_nxt == (m_up ? m_hi : m_lo)) m_up = !m_up;
                            m_word = m_nxt; m_vld = 1; m_phase = 1;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("fword", int'(fword), m_word);
        check("vld",   int'(vld),   int'(m_vld));
        check("busy",  int'(busy),  int'(m_phase != 0));
        check("done",  int'(done),  int'(m_done));
        check("err",   int'(err),   int'(m_err));
    end

    // Handshake / pulse recorder used by the literal expectations.
    int cyc = 0, n_done = 0, n_errp = 0, d_cyc = 0;
    int acc_w[$];
    int acc_c[$];
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (vld && rdy) begin
                acc_w.push_back(int'(fword));
                acc_c.push_back(cyc);
            end
            if (done) begin
                n_done++;
                d_cyc = cyc;
            end
            if (err) n_errp++;
        end
    end

    task automatic clear_rec();
        acc_w.delete(); acc_c.delete(); n_done = 0; n_errp = 0;
    endtask

    task automatic start_sweep(input bit md, input int st, input int lo, input int hi, input int dw);
        mode = md; step = 8'(st); fmin = 16'(lo); fmax = 16'(hi); dwell = 16'(dw);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        int k = 0;
        while (acc_w.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_acc"}, int'(acc_w.size() >= n), 1);
    endtask

    task automatic check_seq(input string name, input int sp, input bit exact);
        if (exact) check({name, "_count"}, acc_w.size(), exp_q.size());
        else       check({name, "_count"}, int'(acc_w.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc_w.size()) begin
                check($sformatf("%s_word%0d", name, i), acc_w[i], exp_q[i]);
                if (sp > 0 && i > 0)
                    check($sformatf("%s_gap%0d", name, i), acc_c[i] - acc_c[i-1], sp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1; rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fword", int'(fword), 0);
        check("rst_vld",   int'(vld),   0);
        check("rst_busy",  int'(busy),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-shot up
        clear_rec();
        start_sweep(1'b0, 4, 100, 110, 3);
        wait_idle("up", 200);
        exp_q = '{100, 104, 108, 110};
        check_seq("up", 4, 1'b1);
        check("up_done_n", n_done, 1);
        if (acc_c.size() > 0) check("up_done_lat", d_cyc - acc_c[acc_c.size()-1], 1);

        // single-shot down, clamps at 0 without wrapping
        clear_rec();
        start_sweep(1'b0, -16, 0, 40, 2);
        wait_idle("down", 200);
        exp_q = '{40, 24, 8, 0};
        check_seq("down", 3, 1'b1);
        check("down_done_n", n_done, 1);

        // triangle, then stop
        clear_rec();
        start_sweep(1'b1, 4, 0, 8, 1);
        wait_acc("tri", 6, 100);
        exp_q = '{0, 4, 8, 4, 0, 4};
        check_seq("tri", 2, 1'b0);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("tri_stop_busy", int'(busy), 0);
        check("tri_stop_vld",  int'(vld),  0);
        check("tri_done_n", n_done, 0);

        // backpressure then enable gap
        clear_rec();
        rdy = 1'b0;
        start_sweep(1'b0, 4, 100, 110, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld",   int'(vld),   1);
            check("bp_fword", int'(fword), 100);
            @(negedge clk);
        end
        rdy = 1'b1;
        wait_acc("bp", 2, 50);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_idle("bp", 200);
        if (acc_c.size() >= 3) begin
            check("bp_gap1", acc_c[1] - acc_c[0], 4);
            check("bp_gap2", acc_c[2] - acc_c[1], 7);
        end
        exp_q = '{100, 104, 108, 110};
        check_seq("bp", 0, 1'b1);

        // rejected start, then zero step
        clear_rec();
        start_sweep(1'b0, 4, 50, 20, 3);
        repeat (2) @(negedge clk);
        check("err_pulses", n_errp, 1);
        check("err_busy", int'(busy), 0);
        clear_rec();
        start_sweep(1'b0, 0, 30, 90, 5);
        wait_idle("zero", 50);
        exp_q = '{30};
        check_seq("zero", 0, 1'b1);
        check("zero_done_n", n_done, 1);

        // asynchronous reset mid-dwell
        clear_rec();
        start_sweep(1'b0, 1, 0, 1000, 20);
        wait_acc("ar", 1, 20);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_fword", int'(fword), 0);
        check("ar_vld",   int'(vld),   0);
        check("ar_busy",  int'(busy),  0);
        check("ar_done",  int'(done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_rec();
        start_sweep(1'b0, 8, 10, 30, 0);
        wait_idle("ar2", 100);
        exp_q = '{10, 18, 26, 30};
        check_seq("ar2", 2, 1'b1);

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            int base;
            en    = ($urandom % 8) != 0;
            rdy   = ($urandom % 4) != 0;
            stop  = ($urandom % 97) == 0;
            start = ($urandom % 6) == 0;
            mode  = 1'($urandom % 2);
            step  = 8'($urandom);
            case ($urandom % 3)
                0:       base = 0;
                1:       base = 65535 - 200;
                default: base = int'($urandom % 65000);
            endcase
            fmin  = 16'(base + int'($urandom % 200));
            fmax  = 16'(base + int'($urandom % 200));
            dwell = 16'($urandom % 5);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sweep scheduler for the DDS phase-increment (frequency word) path. It takes the signed step chosen by the operator step selector and walks the NCO frequency word between programmable bounds. The word advances by one step after a programmable dwell time. Each new word is handed to the NCO register over a valid/ready handshake. Single-shot and continuous triangle sweep modes are supported.

Parameters:
SIZE_VALUE, 7, step is SIZE_VALUE+1 bits signed (matches step selector output)
FREQ_W, 16, frequency word width (unsigned)
DWELL_W, 16, dwell counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  global enable; low pauses the dwell count only
i_start  in  1  one-cycle start pulse, honoured in IDLE only
i_stop  in  1  abort; honoured in every state
i_mode  in  1  0 = single-shot, 1 = triangle (continuous)
i_step  in  SIZE_VALUE+1  signed step, sampled at start
i_f_min  in  FREQ_W  lower bound, sampled at start
i_f_max  in  FREQ_W  upper bound, sampled at start
i_dwell  in  DWELL_W  cycles per word, sampled at start; 0 is treated as 1
o_fword  out  FREQ_W  frequency word to NCO
o_fword_vld  out  1  word valid
i_fword_rdy  in  1  NCO accepted word
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse on single-shot completion
o_err  out  1  one-cycle pulse when start is rejected (f_min > f_max)

Behaviour:
- Reset values: state=IDLE, o_fword=0, o_fword_vld=0, o_done=0, o_err=0, direction=up, dwell count=0.
- States: IDLE, ACK, DWELL, DONE.
- IDLE, i_start & i_en:
  - If f_min > f_max: pulse o_err next cycle and stay in IDLE.
  - Otherwise latch step/bounds/dwell/mode. Load o_fword = f_min if step >= 0, else f_max. Set direction = sign of step. Assert vld and go to ACK, one cycle after start.
- ACK: o_fword_vld=1 and o_fword held stable until i_fword_rdy is sampled high. On acceptance, drop vld next cycle and clear the dwell count. Next state:
  - DONE if single-shot and the word equals the terminal bound (f_max going up, f_min going down), or if step==0.
  - DWELL otherwise.
- DWELL: the count increments only while i_en=1. On the cycle the count reaches dwell-1:
  - next = fword + effective step (step negated when direction is reversed).
  - Computed signed in FREQ_W+2 bits, sign-extending the step.
  - Result is clamped to [f_min, f_max].
  - Load o_fword=next, assert vld, go to ACK.
- Triangle mode: when an update clamps to a bound, flip direction; the following update moves away from that bound. It never finishes; only i_stop ends it.
- Steady-state period with rdy tied high: dwell+1 cycles per word.
- DONE: o_done=1 for one cycle, then IDLE.
- i_stop (highest priority, any state): next cycle state=IDLE and vld=0. o_fword keeps its last value. No o_done pulse. A stop during ACK deliberately breaks the handshake; the NCO keeps its previous word.
- i_start outside IDLE is ignored. Simultaneous start and stop in IDLE: stop wins and start is ignored.
- Bounds equal (f_min==f_max): first word is the bound. Single-shot finishes after one ACK. Triangle re-emits the same word every period.
- Latched configuration is unaffected by input changes during a sweep.
- Reset mid-operation: immediately return to reset values.

Decomposition:
- Package dds_ctrl_pkg holds:
  - sweep_state_t enum (IDLE, ACK, DWELL, DONE)
  - constants MODE_SINGLE=1'b0 and MODE_TRI=1'b1
  - a shared function for sign-extend add with clamp
- One sub-module, sweep_dwell_timer: enable-gated counter with clear, terminal-count compare and the 0-as-1 rule. It outputs a one-cycle o_tc.

Test Plan:
- Single-shot up: f_min=100, f_max=110, step=+4, dwell=3, rdy=1 → words 100,104,108,110 spaced 4 cycles; o_done one cycle after 110 is accepted.
- Single-shot down: step=-16, f_min=0, f_max=40 → 40,24,8,0 then o_done; no underflow wrap.
- Triangle: f_min=0, f_max=8, step=+4, dwell=1 → 0,4,8,4,0,4,8…; o_done never pulses; i_stop returns to IDLE with vld=0 and o_fword holding its last value.
- Backpressure: rdy low 5 cycles during ACK → o_fword and vld stable throughout; dwell count starts only after acceptance; i_en low for 3 DWELL cycles extends the period by 3.
- Errors and corners: f_min=50, f_max=20 → o_err pulse, o_busy stays 0; step=0 → one word (f_min), then o_done.
- Reset mid-DWELL: assert i_rst_n=0 asynchronously → all outputs are 0 and state is IDLE immediately; a fresh start works normally.
